// File: rtl/tempsens_host_link_if.sv
// Host link bundle: command request, status pulses and the serial pair.
// The DUT takes the slave side; the harness driving start/rx takes master.
interface tempsens_host_link_if;
    logic        start;
    logic        rx;
    logic        tx;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        error;

    modport master (
        output start, rx,
        input  tx, busy, result, result_valid, error
    );

    modport slave (
        input  start, rx,
        output tx, busy, result, result_valid, error
    );
endinterface

// File: rtl/tempsens_host_link.sv
// tempsens_host_link: sends one UART command byte, then collects the
// two-byte (LSB, MSB) reply. Optional response timeout: HOST_TIMEOUT_EN.
module tempsens_host_link #(
    parameter int          CLK_FREQ     = 10000,
    parameter int          BAUD         = 1000,
    parameter logic [7:0]  CMD_BYTE     = 8'h01,
    parameter int          TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    tempsens_host_link_if.slave   link
);

    localparam int BIT  = CLK_FREQ / BAUD;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_LSB,
        S_WAIT_MSB,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        R_HUNT,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    state_t      state;
    rx_state_t   rx_state;

    logic        tx_q;
    logic        busy_q;
    logic [15:0] result_q;
    logic        rv_q;
    logic        err_q;

    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;
    logic [8:0]    tx_shift;
    logic [7:0]    lsb_hold;

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_d;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          byte_done;
    logic          frame_err;

    logic          armed;
    logic          rx_fall;

`ifdef HOST_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_BITS * BIT;
    localparam int TW     = $clog2(TO_CYC);
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    assign to_hit = (to_cnt == TW'(TO_CYC - 1));
`endif

    // Listening starts on the command's stop bit so a fast reply is caught.
    assign armed = (state == S_WAIT_LSB) || (state == S_WAIT_MSB) ||
                   ((state == S_SEND) && (tx_idx == 4'd9));
    assign rx_fall = rx_d & ~rx_s2;

    assign link.tx           = tx_q;
    assign link.busy         = busy_q;
    assign link.result       = result_q;
    assign link.result_valid = rv_q;
    assign link.error        = err_q;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= link.rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Bit-level receiver; held in hunt whenever the link is not listening.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= R_HUNT;
            rx_cnt    <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (!armed) begin
                rx_state <= R_HUNT;
                rx_cnt   <= '0;
            end else begin
                unique case (rx_state)
                    R_HUNT: begin
                        rx_cnt <= '0;
                        if (rx_fall) rx_state <= R_START;
                    end
                    R_START: begin
                        if (rx_cnt == CW'(HALF - 1)) begin
                            rx_cnt  <= '0;
                            rx_bits <= '0;
                            rx_state <= rx_s2 ? R_HUNT : R_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    R_DATA: begin
                        if (rx_cnt == CW'(BIT - 1)) begin
                            rx_cnt   <= '0;
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            rx_bits  <= rx_bits + 1'b1;
                            if (rx_bits == 3'd7) rx_state <= R_STOP;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    R_STOP: begin
                        if (rx_cnt == CW'(BIT - 1)) begin
                            rx_cnt    <= '0;
                            rx_state  <= R_HUNT;
                            byte_done <= rx_s2;
                            frame_err <= ~rx_s2;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    default: rx_state <= R_HUNT;
                endcase
            end
        end
    end

    // Transaction FSM with the command transmitter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            lsb_hold <= '0;
`ifdef HOST_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            rv_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (link.start) begin
                        state    <= S_SEND;
                        busy_q   <= 1'b1;
                        tx_q     <= 1'b0;
                        tx_shift <= {1'b1, CMD_BYTE};
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                    end
                end
                S_SEND: begin
                    if (tx_cnt == CW'(BIT - 1)) begin
                        tx_cnt <= '0;
                        if (tx_idx == 4'd9) begin
                            tx_idx <= '0;
                            state  <= S_WAIT_LSB;
`ifdef HOST_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_q     <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_WAIT_LSB: begin
                    if (byte_done) begin
                        lsb_hold <= rx_shift;
                        state    <= S_WAIT_MSB;
`ifdef HOST_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end else if (frame_err) begin
                        err_q <= 1'b1;
                        state <= S_ERR;
`ifdef HOST_TIMEOUT_EN
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_WAIT_MSB: begin
                    if (byte_done) begin
                        result_q <= {rx_shift, lsb_hold};
                        rv_q     <= 1'b1;
                        state    <= S_DONE;
                    end else if (frame_err) begin
                        err_q <= 1'b1;
                        state <= S_ERR;
`ifdef HOST_TIMEOUT_EN
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tempsens_host_link.sv
// Bench for tempsens_host_link: plays the sensor chip, scoreboards the
// result/error pulses against a transaction-level model.
module tb_tempsens_host_link;

    localparam int         BIT = 10;
    localparam logic [7:0] CMD = 8'h01;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tempsens_host_link_if link();

    tempsens_host_link #(
        .CLK_FREQ(10000),
        .BAUD(1000),
        .CMD_BYTE(CMD),
        .TIMEOUT_BITS(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .link(link)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_good = 16'h0000;
    bit          rv_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Model: a good reply yields {msb,lsb}; a bad one errors and keeps result.
    task automatic expect_txn(input logic [7:0] lsb, input logic [7:0] msb,
                              input bit bad);
        exp_t x;
        if (!bad) last_good = {msb, lsb};
        x.is_err = bad;
        x.val    = last_good;
        sb.push_back(x);
    endtask

    // Monitor: pops one expectation per result_valid/error pulse.
    always @(negedge clk) begin
        if (reset) begin
            rv_prev = 1'b0;
        end else begin
            if (rv_prev) chk("busy_low_after_done", link.busy, 0);
            rv_prev = link.result_valid;
            if (link.result_valid || link.error) begin
                chk("rv_err_exclusive", link.result_valid & link.error, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse",
                        {link.result_valid, link.error}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind_is_err", link.error, e.is_err);
                    chk("result_value", link.result, e.val);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            link.rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        link.rx = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        link.start = 1'b1;
        @(negedge clk);
        link.start = 1'b0;
    endtask

    // Every cycle of each command bit must carry that bit.
    task automatic check_frame();
        logic [9:0] f;
        logic       got;
        f = {1'b1, CMD, 1'b0};
        for (int k = 0; k < 10; k++) begin
            got = f[k];
            for (int c = 0; c < BIT; c++) begin
                if (link.tx !== f[k]) got = link.tx;
                @(negedge clk);
            end
            chk($sformatf("tx_bit%0d", k), got, f[k]);
        end
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (link.busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_busy", link.busy, 0);
    endtask

    // rs: cycles after start was taken before the LSB start bit (>=93).
    task automatic run_txn(input logic [7:0] lsb, input logic [7:0] msb,
                           input int rs, input bit bad, input bit glitch,
                           input bit extra_start);
        expect_txn(lsb, msb, bad);
        pulse_start();
        fork
            check_frame();
            begin
                repeat (rs) @(negedge clk);
                if (glitch) begin
                    link.rx = 1'b0;
                    repeat (3) @(negedge clk);
                    link.rx = 1'b1;
                    repeat (20) @(negedge clk);
                end
                send_byte(lsb, 1'b1);
                if (extra_start) begin
                    link.start = 1'b1;
                    @(negedge clk);
                    link.start = 1'b0;
                end
                send_byte(msb, !bad);
            end
        join
        link.rx = 1'b1;
        wait_idle(3000);
        chk("result_hold", link.result, last_good);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic [7:0] a;
        logic [7:0] b;
        int         rs;
        int         cnt;
        bit         bad;
        bit         gl;

        link.start = 1'b0;
        link.rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", link.tx, 1);
        chk("rst_busy", link.busy, 0);
        chk("rst_result", link.result, 0);
        chk("rst_rv", link.result_valid, 0);
        chk("rst_err", link.error, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the command frame aborts at once.
        pulse_start();
        repeat (30) @(negedge clk);
        chk("mid_cmd_busy", link.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx", link.tx, 1);
        chk("async_rst_busy", link.busy, 0);
        chk("async_rst_result", link.result, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (link.tx !== 1'b1 || link.busy !== 1'b0) seen = 1'b1;
        end
        chk("post_rst_idle", seen, 0);

        // Nominal, with a stray start while busy.
        run_txn(8'h34, 8'h12, 100, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (link.tx !== 1'b1 || link.busy !== 1'b0) seen = 1'b1;
        end
        chk("stray_start_ignored", seen, 0);

        // Framing error on the MSB; 16'h1234 must survive.
        run_txn(8'h56, 8'h78, 110, 1'b1, 1'b0, 1'b0);
        run_txn(8'hFF, 8'hFF, 110, 1'b0, 1'b0, 1'b0);
        run_txn(8'hC3, 8'h5A, 105, 1'b0, 1'b1, 1'b0);
        // Fast reply inside the command stop bit.
        run_txn(8'h9E, 8'h27, 93, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            rs  = $urandom_range(93, 140);
            bad = ($urandom_range(0, 4) == 0);
            gl  = (rs >= 100) && ($urandom_range(0, 2) == 0);
            run_txn(a, b, rs, bad, gl, 1'b0);
        end

        // LSB only, then silence.
        pulse_start();
`ifdef HOST_TIMEOUT_EN
        sb.push_back('{1'b1, last_good});
        repeat (100) @(negedge clk);
        send_byte(8'hAA, 1'b1);
        cnt = 0;
        while (!link.error && cnt < 800) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("timeout_near_640_cnt%0d", cnt),
            (cnt >= 620 && cnt <= 660) ? 32'd1 : 32'd0, 1);
        wait_idle(100);
        chk("timeout_result_hold", link.result, last_good);
`else
        repeat (100) @(negedge clk);
        send_byte(8'hAA, 1'b1);
        cnt = 0;
        repeat (800) begin
            @(negedge clk);
            if (link.error) cnt++;
        end
        chk("silent_link_busy", link.busy, 1);
        chk("silent_link_no_err", cnt, 0);
        #2 reset = 1'b1;
        #1;
        last_good = 16'h0000;
        chk("recover_rst_busy", link.busy, 0);
        chk("recover_rst_result", link.result, last_good);
        @(negedge clk);
        reset = 1'b0;
`endif
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
